// File: rtl/multi_port_ram_pkg.sv
// Shared types and helpers for multi_port_ram: sequencer state encoding and word parity.
package multi_port_ram_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam int unsigned MAX_RD = 4;
   localparam int unsigned MAX_DW = 64;

   // Even-parity bit over a zero-extended word; zero padding does not change the result.
   function automatic logic even_parity(input logic [MAX_DW-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer for multi_port_ram: owns CLEAR/IDLE state, the sweep counter, ready,
// and the single storage write port mux (sweep writes vs. accepted user writes).
module ram_clear_seq
   import multi_port_ram_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH  = 4,
   parameter int unsigned          DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  clear_req_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  ready_o,
   output logic                  wr_acc_c_o,
   output logic                  mem_we_c_o,
   output logic [ADDR_WIDTH-1:0] mem_waddr_c_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_c_o
);

   localparam int unsigned          DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
   logic                    ready_q, ready_d;

   // Next state and write-port mux; a clear request wins over a same-edge write.
   always_comb begin
      state_d       = state_q;
      clr_cnt_d     = clr_cnt_q;
      wr_acc_c_o    = 1'b0;
      mem_we_c_o    = 1'b0;
      mem_waddr_c_o = wr_addr_i;
      mem_wdata_c_o = wr_data_i;
      case (state_q)
         CLEAR: begin
            mem_we_c_o    = 1'b1;
            mem_waddr_c_o = clr_cnt_q;
            mem_wdata_c_o = CLEAR_VALUE;
            clr_cnt_d     = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST) state_d = IDLE;
         end
         IDLE: begin
            if (clear_req_i) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end else begin
               wr_acc_c_o = wr_en_i;
               mem_we_c_o = wr_en_i;
            end
         end
         default: state_d = CLEAR;
      endcase
      if (reset_i) begin
         wr_acc_c_o = 1'b0;
         mem_we_c_o = 1'b0;
      end
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ready_q   <= ready_d;
      end
   end

   assign ready_o = ready_q;

endmodule

// File: rtl/multi_port_ram.sv
// Multi-read-port RAM with registered reads, write-first bypass and a hardware clear sweep.
// Optional per-word even parity with error reporting when MULTI_PORT_RAM_PARITY_EN is defined.
module multi_port_ram
   import multi_port_ram_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH  = 4,
   parameter int unsigned          DATA_WIDTH  = 8,
   parameter int unsigned          NUM_RD      = 2,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear_req,
   output logic                         ready,
   input  logic                         wr_en,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic [NUM_RD-1:0]            rd_en,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_valid
`ifdef MULTI_PORT_RAM_PARITY_EN
   ,
   input  logic                         par_inject,
   output logic [NUM_RD-1:0]            rd_par_err
`endif
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic                  wr_acc_c;
   logic                  mem_we_c;
   logic [ADDR_WIDTH-1:0] mem_waddr_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   ram_clear_seq #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .CLEAR_VALUE (CLEAR_VALUE)
   ) u_clear_seq (
      .clk_i         (clk),
      .reset_i       (reset),
      .clear_req_i   (clear_req),
      .wr_en_i       (wr_en),
      .wr_addr_i     (wr_addr),
      .wr_data_i     (wr_data),
      .ready_o       (ready),
      .wr_acc_c_o    (wr_acc_c),
      .mem_we_c_o    (mem_we_c),
      .mem_waddr_c_o (mem_waddr_c),
      .mem_wdata_c_o (mem_wdata_c)
   );

   // Storage is deliberately not reset; the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
   end

`ifdef MULTI_PORT_RAM_PARITY_EN
   logic par_q [DEPTH];
   logic par_wr_c;

   // ready low means the sweep owns the write port.
   assign par_wr_c = !ready ? even_parity(MAX_DW'(CLEAR_VALUE))
                            : (even_parity(MAX_DW'(wr_data)) ^ par_inject);

   always_ff @(posedge clk) begin
      if (mem_we_c) par_q[mem_waddr_c] <= par_wr_c;
   end
`endif

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr_c;
      logic                  hit_c;
      logic                  valid_d, valid_q;
      logic [DATA_WIDTH-1:0] data_d, data_q;

      assign addr_c = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit_c  = wr_acc_c && (addr_c == wr_addr);

      // Reads are accepted whenever idle, including the edge that starts a clear.
      always_comb begin
         valid_d = ready && rd_en[i];
         data_d  = data_q;
         if (valid_d) data_d = hit_c ? wr_data : mem_q[addr_c];
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
         end
      end

      assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
      assign rd_valid[i]                         = valid_q;

`ifdef MULTI_PORT_RAM_PARITY_EN
      logic err_d, err_q;

      assign err_d = valid_d && !hit_c
                     && (par_q[addr_c] != even_parity(MAX_DW'(mem_q[addr_c])));

      always_ff @(posedge clk) begin
         if (reset) err_q <= 1'b0;
         else       err_q <= err_d;
      end

      assign rd_par_err[i] = err_q;
`endif
   end

endmodule

// File: tb/tb_multi_port_ram.sv
// Directed bench for multi_port_ram: an abstract per-edge model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_multi_port_ram;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned NR    = 2;
   localparam int unsigned DEPTH = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             clear_req;
   logic             ready;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic [NR-1:0]    rd_en;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_valid;
   logic             par_inject;
`ifdef MULTI_PORT_RAM_PARITY_EN
   logic [NR-1:0]    rd_par_err;
`endif

   always #5 clk = ~clk;

   multi_port_ram #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .NUM_RD      (NR),
      .CLEAR_VALUE (8'h00)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clear_req  (clear_req),
      .ready      (ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid)
`ifdef MULTI_PORT_RAM_PARITY_EN
      ,
      .par_inject (par_inject),
      .rd_par_err (rd_par_err)
`endif
   );

   int vectors = 0;
   int errors  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Abstract model: a busy countdown, a word array, and per-port last-read registers.
   logic [DW-1:0] m_mem [DEPTH];
   logic          m_bad [DEPTH];
   logic          m_ready;
   int            m_left;
   logic [NR-1:0] m_valid;
   logic [NR-1:0] m_err;
   logic [DW-1:0] m_data [NR];
   bit            m_live = 1'b0;
   logic [AW-1:0] m_a;
   logic          m_byp;

   always @(posedge clk) begin
      if (reset) begin
         m_live  = 1'b1;
         m_ready = 1'b0;
         m_left  = DEPTH;
         m_valid = '0;
         m_err   = '0;
         for (int p = 0; p < NR; p++) m_data[p] = '0;
      end else if (m_live) begin
         if (!m_ready) begin
            m_valid = '0;
            m_err   = '0;
            m_left--;
            if (m_left == 0) begin
               m_ready = 1'b1;
               for (int a = 0; a < DEPTH; a++) begin
                  m_mem[a] = 8'h00;
                  m_bad[a] = 1'b0;
               end
            end
         end else begin
            for (int p = 0; p < NR; p++) begin
               if (rd_en[p]) begin
                  m_a        = rd_addr[p*AW +: AW];
                  m_byp      = wr_en && !clear_req && (m_a == wr_addr);
                  m_data[p]  = m_byp ? wr_data : m_mem[m_a];
                  m_valid[p] = 1'b1;
                  m_err[p]   = !m_byp && m_bad[m_a];
               end else begin
                  m_valid[p] = 1'b0;
                  m_err[p]   = 1'b0;
               end
            end
            if (clear_req) begin
               m_ready = 1'b0;
               m_left  = DEPTH;
            end else if (wr_en) begin
               m_mem[wr_addr] = wr_data;
               m_bad[wr_addr] = par_inject;
            end
         end
      end
      #1;
      if (m_live) begin
         check("model_ready", 32'(ready), 32'(m_ready));
         check("model_rd_valid", 32'(rd_valid), 32'(m_valid));
         for (int p = 0; p < NR; p++)
            check($sformatf("model_rd_data%0d", p), 32'(rd_data[p*DW +: DW]), 32'(m_data[p]));
`ifdef MULTI_PORT_RAM_PARITY_EN
         check("model_rd_par_err", 32'(rd_par_err), 32'(m_err));
`endif
      end
   end

   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NR-1:0] re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic cr, input logic pi);
      wr_en      = we;
      wr_addr    = wa;
      wr_data    = wd;
      rd_en      = re;
      rd_addr    = {a1, a0};
      clear_req  = cr;
      par_inject = pi;
      @(negedge clk);
   endtask

   task automatic idle_cyc();
      drive(1'b0, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en = '0; rd_addr = '0; clear_req = 1'b0; par_inject = 1'b0;
      repeat (2) @(negedge clk);

      // Power-up sweep: ready rises on the 16th edge after release.
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         idle_cyc();
         check("ready_after_reset", 32'(ready), 32'(k == 16));
      end

      // Every word reads back as the clear value.
      for (int a = 0; a < 16; a++) begin
         drive(1'b0, 4'd0, 8'h00, 2'b01, 4'(a), 4'd0, 1'b0, 1'b0);
         check("cleared_word", 32'(rd_data[7:0]), 32'h00);
         check("cleared_valid", 32'(rd_valid[0]), 32'h1);
      end

      // Two writes, then a dual-port read.
      drive(1'b1, 4'd3, 8'hA5, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
      drive(1'b1, 4'd9, 8'h3C, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 8'h00, 2'b11, 4'd3, 4'd9, 1'b0, 1'b0);
      check("dual_read_data", 32'(rd_data), 32'h3CA5);
      check("dual_read_valid", 32'(rd_valid), 32'h3);

      // Same-cycle write/read bypass on both ports, then a plain re-read.
      drive(1'b1, 4'd7, 8'h5A, 2'b11, 4'd7, 4'd7, 1'b0, 1'b0);
      check("bypass_data", 32'(rd_data), 32'h5A5A);
      drive(1'b0, 4'd0, 8'h00, 2'b11, 4'd7, 4'd7, 1'b0, 1'b0);
      check("reread_data", 32'(rd_data), 32'h5A5A);

      // Clear request with a colliding write and a read of pre-clear data.
      drive(1'b1, 4'd2, 8'hFF, 2'b01, 4'd3, 4'd0, 1'b1, 1'b0);
      check("preclear_read", 32'(rd_data[7:0]), 32'hA5);
      check("preclear_valid", 32'(rd_valid), 32'h1);
      check("clear_ready_low", 32'(ready), 32'h0);
      for (int k = 1; k <= 16; k++) begin
         drive(1'b0, 4'd0, 8'h00, 2'b11, 4'd2, 4'd3, 1'b0, 1'b0);
         check("sweep_valid", 32'(rd_valid), 32'h0);
         check("sweep_ready", 32'(ready), 32'(k == 16));
      end
      drive(1'b0, 4'd0, 8'h00, 2'b11, 4'd2, 4'd3, 1'b0, 1'b0);
      check("postclear_data", 32'(rd_data), 32'h0000);
      check("postclear_valid", 32'(rd_valid), 32'h3);

      // Reset in the middle of a sweep restarts it from address 0.
      drive(1'b1, 4'd12, 8'h77, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
      repeat (8) idle_cyc();
      reset = 1'b1;
      idle_cyc();
      check("midsweep_reset_ready", 32'(ready), 32'h0);
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         idle_cyc();
         check("restart_ready", 32'(ready), 32'(k == 16));
      end
      drive(1'b0, 4'd0, 8'h00, 2'b10, 4'd0, 4'd12, 1'b0, 1'b0);
      check("restart_cleared", 32'(rd_data[15:8]), 32'h00);

`ifdef MULTI_PORT_RAM_PARITY_EN
      // Injected parity fault is reported; a clean rewrite and a bypassed read are not.
      drive(1'b1, 4'd4, 8'h01, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 8'h00, 2'b01, 4'd4, 4'd0, 1'b0, 1'b0);
      check("par_err_inject", 32'(rd_par_err), 32'h1);
      check("par_err_valid", 32'(rd_valid), 32'h1);
      drive(1'b1, 4'd4, 8'h01, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 8'h00, 2'b01, 4'd4, 4'd0, 1'b0, 1'b0);
      check("par_err_clean", 32'(rd_par_err), 32'h0);
      drive(1'b1, 4'd4, 8'h03, 2'b01, 4'd4, 4'd0, 1'b0, 1'b1);
      check("par_err_bypass", 32'(rd_par_err), 32'h0);
      drive(1'b0, 4'd0, 8'h00, 2'b01, 4'd4, 4'd0, 1'b0, 1'b0);
      check("par_err_stored", 32'(rd_par_err), 32'h1);
`endif

      idle_cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
